// File: rtl/apb_spi_regif.sv
// APB3 register front end for the SPI core: CTRL/BAUD/STATUS/DATA map,
// TX/RX data FIFOs, programmable wait states, PSLVERR and a registered irq.
module apb_spi_regif #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              spe,
    output logic              mstr,
    output logic              cpol,
    output logic              cpha,
    output logic [7:0]        baud_div,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_wcnt;
    logic [5:0]        r_ctrl;
    logic [7:0]        r_baud;
    logic              r_rx_ovr, r_irq;
    logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [CNT_W-1:0]  r_tx_cnt, r_rx_cnt;

    logic w_sel_ctrl, w_sel_baud, w_sel_stat, w_sel_data, w_unmapped;
    logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic w_done, w_err, w_wr_ok, w_rd_ok;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic w_flush, w_ovr_set, w_ovr_clr;
    logic [DATA_W-1:0] w_rdata;

    assign w_sel_ctrl = (PADDR == ADDR_W'(0));
    assign w_sel_baud = (PADDR == ADDR_W'(1));
    assign w_sel_stat = (PADDR == ADDR_W'(2));
    assign w_sel_data = (PADDR == ADDR_W'(3));
    assign w_unmapped = (PADDR > ADDR_W'(3));

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == FULL_CNT);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == FULL_CNT);

    // An erroring transfer completes normally but suppresses every side effect.
    assign w_err   = w_unmapped | (w_sel_data & PWRITE & w_tx_full)
                   | (w_sel_data & !PWRITE & w_rx_empty);
    assign w_done  = PSEL & PENABLE & PREADY;
    assign w_wr_ok = w_done & !w_err & PWRITE;
    assign w_rd_ok = w_done & !w_err & !PWRITE;

    assign tx_valid  = !w_tx_empty & r_ctrl[0];
    assign tx_data   = r_tx_mem[r_tx_rp];
    assign w_tx_push = w_wr_ok & w_sel_data;
    assign w_tx_pop  = tx_valid & tx_ready;
    assign w_rx_pop  = w_rd_ok & w_sel_data;
    // A full RX FIFO still accepts a word when an APB pop frees a slot on the same edge.
    assign w_rx_push = rx_valid & (!w_rx_full | w_rx_pop);
    assign w_ovr_set = rx_valid & w_rx_full & !w_rx_pop;
    assign w_ovr_clr = w_wr_ok & w_sel_stat & PWDATA[4];
    assign w_flush   = w_wr_ok & w_sel_ctrl & r_ctrl[0] & !PWDATA[0];

    assign spe      = r_ctrl[0];
    assign mstr     = r_ctrl[1];
    assign cpol     = r_ctrl[2];
    assign cpha     = r_ctrl[3];
    assign baud_div = r_baud;
    assign irq      = r_irq;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (PSEL && !PENABLE) w_state_nxt = S_ACCESS;
            S_ACCESS: if (!PSEL || (PENABLE && PREADY)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        PREADY  = (r_state == S_ACCESS) && (r_wcnt == 4'(WAIT_STATES));
        PSLVERR = PREADY & w_err;
        PRDATA  = (PREADY && !PWRITE && !w_err) ? w_rdata : '0;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                  r_wcnt <= '0;
        else if (r_state == S_IDLE)  r_wcnt <= '0;
        else if (!PREADY)            r_wcnt <= r_wcnt + 4'd1;
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel_ctrl)      w_rdata[5:0] = r_ctrl;
        else if (w_sel_baud) w_rdata[7:0] = r_baud;
        else if (w_sel_stat) w_rdata[4:0] = {r_rx_ovr, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
        else if (w_sel_data) w_rdata = r_rx_mem[r_rx_rp];
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_ctrl   <= '0;
            r_baud   <= 8'h02;
            r_rx_ovr <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ok && w_sel_ctrl) r_ctrl <= PWDATA[5:0];
            if (w_wr_ok && w_sel_baud) r_baud <= PWDATA[7:0];
            if (w_flush)        r_rx_ovr <= 1'b0;
            else if (w_ovr_set) r_rx_ovr <= 1'b1;
            else if (w_ovr_clr) r_rx_ovr <= 1'b0;
            r_irq <= (r_ctrl[4] & w_tx_empty) | (r_ctrl[5] & !w_rx_empty) | r_rx_ovr;
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= PWDATA;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET || w_flush) begin
            r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
            r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            r_tx_cnt <= r_tx_cnt + CNT_W'(w_tx_push) - CNT_W'(w_tx_pop);
            r_rx_cnt <= r_rx_cnt + CNT_W'(w_rx_push) - CNT_W'(w_rx_pop);
        end
    end
endmodule

// File: tb/tb_apb_spi_regif.sv
// Bench for apb_spi_regif: register-map vector table, scoreboarded APB completions,
// plus hand sequences for wait states, FIFOs, overrun, flush, abort and mid-transfer reset.
module tb_apb_spi_regif;
    logic        clk = 0, rst = 1;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [2:0]  paddr = 0;
    logic [31:0] pwdata = 0, prdata, tx_data, rx_data = 0;
    logic        pready, pslverr, spe, mstr, cpol, cpha, tx_valid, tx_ready = 0, rx_valid = 0, irq;
    logic [7:0]  baud_div;

    logic        psel2 = 0, penable2 = 0, pwrite2 = 0;
    logic [2:0]  paddr2 = 0;
    logic [31:0] pwdata2 = 0, prdata2, txd2, rxd2 = 0;
    logic        pready2, pslverr2, spe2, mstr2, cpol2, cpha2, txv2, irq2, txr2 = 0, rxv2 = 0;
    logic [7:0]  baud2;

    always #5 clk = ~clk;

    apb_spi_regif #(.DATA_W(32), .ADDR_W(3), .FIFO_DEPTH(4), .WAIT_STATES(0)) u_dut (
        .PCLK(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .spe(spe), .mstr(mstr), .cpol(cpol), .cpha(cpha), .baud_div(baud_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq));

    apb_spi_regif #(.DATA_W(32), .ADDR_W(3), .FIFO_DEPTH(4), .WAIT_STATES(3)) u_dut_ws (
        .PCLK(clk), .PRESET(rst), .PSEL(psel2), .PENABLE(penable2), .PWRITE(pwrite2),
        .PADDR(paddr2), .PWDATA(pwdata2), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2),
        .spe(spe2), .mstr(mstr2), .cpol(cpol2), .cpha(cpha2), .baud_div(baud2),
        .tx_data(txd2), .tx_valid(txv2), .tx_ready(txr2),
        .rx_data(rxd2), .rx_valid(rxv2), .irq(irq2));

    typedef struct {
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    exp_t sb[$];
    logic [31:0] tx_model[$];
    vec_t tbl[12];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every PSEL&PENABLE&PREADY cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (psel && penable && pready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_completion: got addr %0d want none", paddr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pslverr", {31'b0, pslverr}, {31'b0, e.err});
                if (e.chk_rd) chk("prdata", prdata, e.rd);
            end
        end
    end

    task automatic apb(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, output int lat);
        exp_t e;
        e.chk_rd = !wr; e.rd = erd; e.err = eerr;
        sb.push_back(e);
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1;
        lat = 0;
        while (!pready && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!pready) begin
            n_cmp++; n_bad++;
            $display("FAIL apb_timeout: got no PREADY want PREADY within 32 cycles");
            void'(sb.pop_back());
        end
        @(posedge clk); #1;
        psel = 0; penable = 0;
    endtask

    task automatic rx_pulse(input logic [31:0] d);
        @(posedge clk); #1;
        rx_valid = 1; rx_data = d;
        @(posedge clk); #1;
        rx_valid = 0;
    endtask

    initial begin
        int lat;
        tbl[0]  = '{1'b1, 3'd0, 32'h03,  32'h0,  1'b0};
        tbl[1]  = '{1'b0, 3'd0, 32'h0,   32'h03, 1'b0};
        tbl[2]  = '{1'b0, 3'd1, 32'h0,   32'h02, 1'b0};
        tbl[3]  = '{1'b0, 3'd2, 32'h0,   32'h05, 1'b0};
        tbl[4]  = '{1'b0, 3'd5, 32'h0,   32'h0,  1'b1};
        tbl[5]  = '{1'b1, 3'd7, 32'hFF,  32'h0,  1'b1};
        tbl[6]  = '{1'b0, 3'd3, 32'h0,   32'h0,  1'b1};
        tbl[7]  = '{1'b1, 3'd1, 32'h40,  32'h0,  1'b0};
        tbl[8]  = '{1'b0, 3'd1, 32'h0,   32'h40, 1'b0};
        tbl[9]  = '{1'b1, 3'd2, 32'hFF,  32'h0,  1'b0};
        tbl[10] = '{1'b0, 3'd2, 32'h0,   32'h05, 1'b0};
        tbl[11] = '{1'b0, 3'd4, 32'h0,   32'h0,  1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", {31'b0, pready}, 0);
        chk("rst_prdata", prdata, 0);
        chk("rst_baud", {24'b0, baud_div}, 32'h02);
        chk("rst_txv_irq_spe", {29'b0, tx_valid, irq, spe}, 0);
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 12; i++) begin
            apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err, lat);
            chk("latency_ws0", lat, 0);
        end
        @(negedge clk);
        chk("ctrl_outs", {28'b0, cpha, cpol, mstr, spe}, 32'h3);
        chk("baud_out", {24'b0, baud_div}, 32'h40);

        // Abort: PSEL dropped during ACCESS must not write CTRL.
        psel = 1; penable = 0; pwrite = 1; paddr = 0; pwdata = 0;
        @(posedge clk); #1;
        psel = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_idle", {31'b0, pready}, 0);
        apb(0, 0, 0, 32'h03, 0, lat);

        // Wait states on the WAIT_STATES=3 instance.
        psel2 = 1; pwrite2 = 1; paddr2 = 1; pwdata2 = 32'h10;
        @(posedge clk); #1;
        penable2 = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("ws3_pready", {31'b0, pready2}, (k == 4) ? 1 : 0);
        end
        chk("ws3_baud_before", {24'b0, baud2}, 32'h02);
        chk("ws3_err", {31'b0, pslverr2}, 0);
        @(posedge clk); #1;
        psel2 = 0; penable2 = 0;
        @(negedge clk);
        chk("ws3_baud_after", {24'b0, baud2}, 32'h10);
        chk("ws3_idle", {31'b0, pready2} | prdata2 | txd2 & 0, 0);

        // TX fill to full, one rejected push, then drain.
        for (int i = 0; i < 5; i++) begin
            logic [31:0] d;
            d = 32'hA1 + i;
            if (i < 4) tx_model.push_back(d);
            apb(1, 3, d, 0, (i == 4), lat);
        end
        apb(0, 2, 0, 32'h06, 0, lat);
        @(posedge clk); #1;
        tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            @(negedge clk);
            d = tx_model.pop_front();
            chk("tx_valid", {31'b0, tx_valid}, 1);
            chk("tx_data", tx_data, d);
            @(posedge clk);
        end
        #1 tx_ready = 0;
        apb(0, 2, 0, 32'h05, 0, lat);

        // RX fill with overrun, drain, underflow, W1C.
        for (int i = 0; i < 5; i++) rx_pulse(32'hB1 + i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("irq_ovr", {31'b0, irq}, 1);
        apb(0, 2, 0, 32'h19, 0, lat);
        for (int i = 0; i < 4; i++) apb(0, 3, 0, 32'hB1 + i, 0, lat);
        apb(0, 3, 0, 0, 1, lat);
        apb(0, 2, 0, 32'h15, 0, lat);
        apb(1, 2, 32'h10, 0, 0, lat);
        apb(0, 2, 0, 32'h05, 0, lat);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("irq_cleared", {31'b0, irq}, 0);

        // SPE 1->0 flushes both FIFOs.
        apb(1, 3, 32'hC1, 0, 0, lat);
        apb(1, 3, 32'hC2, 0, 0, lat);
        rx_pulse(32'hD1);
        apb(1, 0, 32'h02, 0, 0, lat);
        apb(0, 2, 0, 32'h05, 0, lat);
        @(negedge clk);
        chk("flush_ctrl", {30'b0, mstr, spe}, 32'h2);

        // TXIE with empty TX raises irq.
        apb(1, 0, 32'h10, 0, 0, lat);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("irq_txie", {31'b0, irq}, 1);

        // Reset during ACCESS of a DATA write with two TX entries.
        apb(1, 0, 32'h01, 0, 0, lat);
        apb(1, 3, 32'hE1, 0, 0, lat);
        apb(1, 3, 32'hE2, 0, 0, lat);
        psel = 1; penable = 0; pwrite = 1; paddr = 3; pwdata = 32'hE3;
        @(posedge clk); #1;
        penable = 1;
        #1 rst = 1;
        @(negedge clk);
        chk("midrst_pready", {31'b0, pready}, 0);
        @(posedge clk); #1;
        psel = 0; penable = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_outs", {30'b0, tx_valid, irq}, 0);
        chk("midrst_spe", {31'b0, spe}, 0);
        apb(0, 2, 0, 32'h05, 0, lat);
        apb(0, 0, 0, 32'h00, 0, lat);
        @(negedge clk);
        chk("midrst_irq", {31'b0, irq}, 0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apb_spi_regif.md
Name: apb_spi_regif

Overview:
- Parametrised APB3 slave register interface for the SPI core.
- Successor to the single-register APB front end. Adds:
  - a decoded register map;
  - TX and RX data FIFOs of configurable depth;
  - programmable wait states;
  - PSLVERR error signalling;
  - an interrupt output.
- Sits between the APB interconnect and the SPI shift engine.

Parameters:
- DATA_W, 32: APB data width and FIFO entry width.
- ADDR_W, 3: PADDR width. Word index; register select uses PADDR[ADDR_W-1:0].
- FIFO_DEPTH, 4: entries per FIFO. Power of 2, at least 2.
- WAIT_STATES, 0: extra ACCESS cycles before PREADY is asserted (0..15).

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_W  register index.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data. Valid only while PREADY=1, otherwise 0.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error. Valid only while PREADY=1, otherwise 0.
- spe  out  1  SPI enable (CTRL[0]).
- mstr  out  1  master mode (CTRL[1]).
- cpol  out  1  clock polarity (CTRL[2]).
- cpha  out  1  clock phase (CTRL[3]).
- baud_div  out  8  baud divider (BAUD[7:0]).
- tx_data  out  DATA_W  head of the TX FIFO.
- tx_valid  out  1  !tx_empty && spe.
- tx_ready  in  1  engine accepts tx_data.
- rx_data  in  DATA_W  received word.
- rx_valid  in  1  rx_data strobe, single cycle.
- irq  out  1  interrupt, registered.

Behaviour:
- Register map:
  - 0 CTRL, RW: [0] SPE, [1] MSTR, [2] CPOL, [3] CPHA, [4] TXIE, [5] RXIE. Reset 0.
  - 1 BAUD, RW: [7:0]. Reset 8'h02.
  - 2 STATUS: [0] TX_EMPTY, [1] TX_FULL, [2] RX_EMPTY, [3] RX_FULL, [4] RX_OVR (sticky). Writing 1 to bit 4 clears RX_OVR; all other bits are read-only and writes to them are ignored.
  - 3 DATA: a write pushes TX; a read pops RX.
  - 4 and above: unmapped.
  - Unused read bits return 0.
- APB FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on a sampled PSEL=1, PENABLE=0 (setup phase); wcnt is cleared to 0.
  - ACCESS: PREADY = (wcnt == WAIT_STATES), combinational. wcnt increments each cycle while PREADY=0.
  - The completing edge is PSEL && PENABLE && PREADY. All side effects happen on that edge only. The FSM then returns to IDLE, so a back-to-back setup can be sampled in the next cycle.
  - PSEL=0 while in ACCESS: abort to IDLE with no side effect.
- Latency: with WAIT_STATES=0 a transfer takes 2 cycles (setup + access). Each wait state adds 1 cycle.
- PSLVERR=1 on completion for:
  - an unmapped address;
  - a write to DATA while TX_FULL;
  - a read of DATA while RX_EMPTY.
  An erroring transfer has no side effect and returns PRDATA = 0.
- TX FIFO:
  - Pushes on a successful APB write to DATA; pops when tx_valid && tx_ready.
  - Fullness is evaluated before a same-cycle pop: a push while full is rejected even if a pop occurs on the same edge.
  - A push and a pop on the same edge while not full/empty both take effect.
  - Occupancy counter is $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- RX FIFO:
  - Pushes on rx_valid; pops on a successful APB read of DATA.
  - rx_valid while full: if an APB pop happens on the same edge, the push is accepted and there is no overrun. Otherwise the word is dropped and RX_OVR is set.
  - A set of RX_OVR takes priority over a same-cycle W1C clear.
- CTRL SPE written 1 -> 0: both FIFOs are flushed (pointers and counts zeroed) and RX_OVR is cleared on the same edge.
- irq is registered: next value = (TXIE & TX_EMPTY) | (RXIE & !RX_EMPTY) | RX_OVR, computed from the current-cycle state.
- Reset (PRESET=1, any time, including mid-transfer):
  - FSM to IDLE, wcnt = 0;
  - all registers to their reset values;
  - FIFOs empty, RX_OVR = 0;
  - outputs 0: PREADY, PSLVERR, PRDATA, tx_valid, irq.
  The interrupted transfer is lost.

Test Plan:
- Write CTRL=0x03, then read CTRL, with WAIT_STATES=0 -> read returns 0x00000003 with PREADY on the 2nd cycle of each transfer; spe=1, mstr=1, PSLVERR=0.
- Rebuild with WAIT_STATES=3; write BAUD=0x10 -> PREADY asserted exactly 3 cycles after the ACCESS phase begins; baud_div=0x10 only after the completing edge.
- FIFO_DEPTH=4, tx_ready=0, SPE=1: write DATA 5 times (0xA1..0xA5) -> first four PSLVERR=0, fifth PSLVERR=1, TX_FULL=1. Then raise tx_ready for 4 cycles -> tx_data sequence A1, A2, A3, A4, and TX_EMPTY=1.
- Pulse rx_valid 5 times (0xB1..0xB5) with no reads -> RX_FULL=1, RX_OVR=1, irq=1. Reads return B1..B4; a 5th read gives PSLVERR=1 and PRDATA=0. Write STATUS=0x10 -> RX_OVR=0.
- Read address 5, and separately drop PSEL during ACCESS -> the first gives PSLVERR=1, PRDATA=0; the second leaves no state change and the FSM returns to IDLE.
- Assert PRESET during the ACCESS of a DATA write with 2 entries in TX -> on the following cycles PREADY=0, TX_EMPTY=1, CTRL=0, irq=0.
